int_ctrl_prio: RTL and testbench
================================

// Module: int_ctrl_prio
// PURPOSE
//  Parametrised interrupt controller placed between the external IRQ lines and the uc.
//  Holds the pending ("solicitud") and in-service ("atencion") registers; masks, prioritises
//  and nests requests; presents one registered request plus a vector to the core.
//  Highest index = highest priority.
//  Handshakes with the core: int_ack on call-interrupt, reti on return-from-interrupt.
// PARAMETERS
//  N_IRQ     8         number of interrupt lines (2..32)
//  ID_W      3         id width, = $clog2(N_IRQ)
//  VEC_W     10        vector/PC width
//  VEC_BASE  10'h3C0   address of the line-0 handler
//  VEC_SHIFT 2         handler spacing = 2**VEC_SHIFT words
//  TRIG_EDGE {N_IRQ{1'b1}}  per line: 1 = rising-edge, 0 = level
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low
//  irq        in   N_IRQ  external lines, asynchronous to clk
//  mask_we    in   1      load mask_wdata into mask register
//  mask_wdata in   N_IRQ  1 = line enabled
//  int_ack    in   1      1-cycle pulse: core has pushed PC and jumped to int_vec
//  reti       in   1      1-cycle pulse: core is executing reti
//  int_req    out  1      registered request to uc
//  int_vec    out  VEC_W  VEC_BASE + (int_id << VEC_SHIFT); valid while int_req=1
//  int_id     out  ID_W   line being requested
//  pending    out  N_IRQ  pending register
//  in_service out  N_IRQ  in-service register
//  mask       out  N_IRQ  mask register
//  bad_reti   out  1      1-cycle pulse: reti with in_service==0
// BEHAVIOUR
//  Reset (reset=0, async): sync stages, pending, in_service, mask=0; state IDLE;
//   int_req=0, int_id=0, int_vec=VEC_BASE, bad_reti=0.
//  Input path: 2-FF synchroniser per line, then the edge detector (prev-sample register).
//   Edge line: pending bit set on a 0->1 of the synced value; cleared only by int_ack of that id.
//   Level line: pending bit = synced level each cycle (ack does not clear it).
//   Latency: irq rises before edge k -> pending set at edge k+2 -> int_req=1 at edge k+3.
//  Arbitration (combinational): cand = highest set bit of (pending & mask);
//   top_is = highest set bit of in_service (-1 if none).
//   Request allowed only if cand exists and cand > top_is (strict nesting, no same-level re-entry).
//  FSM:
//   IDLE: if allowed -> REQ; latch int_id=cand, int_vec; int_req=1 from the next edge.
//   REQ: int_id/int_vec frozen, even if a higher line or a mask write arrives. Higher lines wait.
//    int_ack -> in_service[int_id]=1, clear pending[int_id] (edge lines), int_req=0, go to WAIT.
//   WAIT: one cycle with int_req=0 so the uc sees the drop; then IDLE re-arbitrates.
//  reti (any state): clear bit top_is of in_service. If in_service==0 -> no change, bad_reti pulse.
//  reti and int_ack in the same cycle: both apply (clear old top_is, set new id).
//  Edge on a line in the same cycle as its ack-clear: set wins (the new request is kept).
//  mask_we: takes effect at the next edge; it does not affect an issued REQ or in_service.
//  int_ack in IDLE/WAIT: ignored.
//  reset asserted mid-REQ: immediate return to the reset values; no ack is expected afterwards.
// TESTING
//  1 reset; mask=8'hFF; pulse irq[3] before edge 0 -> pending[3]@2, int_req@3, int_vec=10'h3CC,
//    int_id=3; ack -> in_service=8'h08, pending=0, int_req=0.
//  2 in_service[3] set; raise irq[5] -> req id 5 (nesting); ack; raise irq[2] -> no req;
//    reti -> in_service=8'h08; reti -> 0; id 2 is then requested.
//  3 irq[1] and irq[6] rise together -> id 6 first; after ack, id 1 is held off until reti.
//  4 mask=8'hF7; edge on irq[3] -> pending[3]=1, no req; write mask=8'hFF -> req id 3
//    two edges later.
//  5 TRIG_EDGE[0]=0; hold irq[0] high: ack, reti -> re-requested; edge line irq[4] is not re-requested.
//  6 reti with in_service=0 -> bad_reti 1 cycle, regs unchanged; reset=0 during REQ ->
//    int_req=0 asynchronously.

Source files
------------

// File: rtl/int_ctrl_prio.sv
// Prioritised, nesting interrupt controller: per-line sync/edge capture feeding a
// masked highest-index arbiter and a registered REQ/ack/reti handshake to the core.

module int_ctrl_prio_lane #(
  parameter bit TRIG = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic ack_clr,
  output logic pending
);
  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
      // A fresh rising edge beats an ack-clear landing in the same cycle
      if (TRIG) pending <= (sync2 & ~prev) | (pending & ~ack_clr);
      else      pending <= sync2;
    end
  end
endmodule

module int_ctrl_prio #(
  parameter int                 N_IRQ     = 8,
  parameter int                 ID_W      = 3,
  parameter int                 VEC_W     = 10,
  parameter logic [VEC_W-1:0]   VEC_BASE  = 10'h3C0,
  parameter int                 VEC_SHIFT = 2,
  parameter logic [N_IRQ-1:0]   TRIG_EDGE = {N_IRQ{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             reti,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [ID_W-1:0]  int_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] mask,
  output logic             bad_reti
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic [N_IRQ-1:0] ack_vec, reti_clr, req_bits;
  logic             cand_vld, top_vld, allowed, ack_fire;
  logic [ID_W-1:0]  cand_id, top_id;

  assign ack_fire = (state == REQ) && int_ack;
  assign ack_vec  = ack_fire ? (N_IRQ'(1) << int_id) : '0;

  genvar g;
  generate
    for (g = 0; g < N_IRQ; g++) begin : g_lane
      int_ctrl_prio_lane #(.TRIG(TRIG_EDGE[g])) u_lane (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq[g]),
        .ack_clr (ack_vec[g]),
        .pending (pending[g])
      );
    end
  endgenerate

  assign req_bits = pending & mask;

  // Ascending scans leave the highest set index in the result
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    top_vld  = 1'b0;
    top_id   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (req_bits[i]) begin
        cand_vld = 1'b1;
        cand_id  = ID_W'(i);
      end
      if (in_service[i]) begin
        top_vld = 1'b1;
        top_id  = ID_W'(i);
      end
    end
  end

  assign allowed  = cand_vld && (!top_vld || (cand_id > top_id));
  assign reti_clr = (reti && top_vld) ? (N_IRQ'(1) << top_id) : '0;
  assign int_req  = (state == REQ);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (allowed) state_nxt = REQ;
      REQ:     if (int_ack) state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      int_id     <= '0;
      int_vec    <= VEC_BASE;
      in_service <= '0;
      mask       <= '0;
      bad_reti   <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_service <= (in_service & ~reti_clr) | ack_vec;
      bad_reti   <= reti && (in_service == '0);
      if (mask_we) mask <= mask_wdata;
      // id/vector are captured only on the IDLE->REQ transition and frozen until ack
      if (state == IDLE && allowed) begin
        int_id  <= cand_id;
        int_vec <= VEC_BASE + (VEC_W'(cand_id) << VEC_SHIFT);
      end
    end
  end
endmodule

// File: tb/tb_int_ctrl_prio.sv
// Self-checking bench for int_ctrl_prio: expected request id/vector pairs are queued when
// an interrupt is raised and compared when the controller raises int_req.
module tb_int_ctrl_prio;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       int_ack = 1'b0;
  logic       reti = 1'b0;
  logic       int_req;
  logic [9:0] int_vec;
  logic [2:0] int_id;
  logic [7:0] pending, in_service, mask;
  logic       bad_reti;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] id;
    logic [9:0] vec;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int         line;
    logic [2:0] id;
    logic [9:0] vec;
    logic [7:0] is_exp;
  } vec_t;
  vec_t tbl[4];

  int_ctrl_prio #(
    .N_IRQ(8), .ID_W(3), .VEC_W(10), .VEC_BASE(10'h3C0), .VEC_SHIFT(2),
    .TRIG_EDGE(8'hFE)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .reti(reti), .int_req(int_req), .int_vec(int_vec),
    .int_id(int_id), .pending(pending), .in_service(in_service), .mask(mask),
    .bad_reti(bad_reti)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_irq(input logic [7:0] lines);
    irq = irq | lines;
    tick();
    irq = irq & ~lines;
  endtask

  task automatic expect_req(input logic [2:0] id, input logic [9:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input string nm);
    exp_t e;
    int n = 0;
    while (!int_req && n < 12) begin
      tick();
      n++;
    end
    chk({nm, "_req"}, 32'(int_req), 32'd1);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty expected entry", nm);
    end else begin
      e = exp_q.pop_front();
      if (int_req) begin
        chk({nm, "_id"}, 32'(int_id), 32'(e.id));
        chk({nm, "_vec"}, 32'(int_vec), 32'(e.vec));
      end
    end
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic idle_no_req(input string nm, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (int_req) seen = 1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    tbl[0] = '{line: 3, id: 3'd3, vec: 10'h3CC, is_exp: 8'h08};
    tbl[1] = '{line: 7, id: 3'd7, vec: 10'h3DC, is_exp: 8'h80};
    tbl[2] = '{line: 1, id: 3'd1, vec: 10'h3C4, is_exp: 8'h02};
    tbl[3] = '{line: 4, id: 3'd4, vec: 10'h3D0, is_exp: 8'h10};

    // reset state
    tick(); tick();
    chk("rst_req", 32'(int_req), 32'd0);
    chk("rst_id", 32'(int_id), 32'd0);
    chk("rst_vec", 32'(int_vec), 32'h3C0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_is", 32'(in_service), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_bad", 32'(bad_reti), 32'd0);
    #2 reset = 1'b1;
    tick();
    write_mask(8'hFF);
    chk("mask_ff", 32'(mask), 32'hFF);

    // 1: latency and basic request/ack
    expect_req(3'd3, 10'h3CC);
    pulse_irq(8'h08);               // edge 0
    tick();                         // edge 1
    chk("t1_pend_e1", 32'(pending), 32'd0);
    tick();                         // edge 2
    chk("t1_pend_e2", 32'(pending), 32'h08);
    chk("t1_req_e2", 32'(int_req), 32'd0);
    tick();                         // edge 3
    wait_req("t1");
    do_ack();
    chk("t1_is", 32'(in_service), 32'h08);
    chk("t1_pend", 32'(pending), 32'd0);
    chk("t1_req_drop", 32'(int_req), 32'd0);

    // 2: nesting and hold-off of a lower line
    expect_req(3'd5, 10'h3D4);
    pulse_irq(8'h20);
    wait_req("t2_n5");
    do_ack();
    chk("t2_is5", 32'(in_service), 32'h28);
    pulse_irq(8'h04);
    idle_no_req("t2_hold2", 6);
    chk("t2_pend2", 32'(pending), 32'h04);
    do_reti();
    chk("t2_reti1", 32'(in_service), 32'h08);
    chk("t2_noreq", 32'(int_req), 32'd0);
    expect_req(3'd2, 10'h3C8);
    do_reti();
    chk("t2_reti2", 32'(in_service), 32'd0);
    wait_req("t2_n2");
    do_ack();
    chk("t2_is2", 32'(in_service), 32'h04);
    do_reti();

    // 3: simultaneous lines, higher first, lower held until reti
    expect_req(3'd6, 10'h3D8);
    pulse_irq(8'h42);
    wait_req("t3_n6");
    do_ack();
    chk("t3_is6", 32'(in_service), 32'h40);
    chk("t3_pend1", 32'(pending), 32'h02);
    idle_no_req("t3_hold1", 5);
    expect_req(3'd1, 10'h3C4);
    do_reti();
    wait_req("t3_n1");
    do_ack();
    do_reti();
    chk("t3_is0", 32'(in_service), 32'd0);

    // 4: masked line stays pending, unmask releases it
    write_mask(8'hF7);
    pulse_irq(8'h08);
    idle_no_req("t4_masked", 4);
    chk("t4_pend3", 32'(pending), 32'h08);
    expect_req(3'd3, 10'h3CC);
    write_mask(8'hFF);
    chk("t4_req_e1", 32'(int_req), 32'd0);
    tick();
    chk("t4_req_e2", 32'(int_req), 32'd1);
    wait_req("t4");
    do_ack();
    do_reti();

    // 5: level line re-requests, edge line does not
    irq[0] = 1'b1;
    expect_req(3'd0, 10'h3C0);
    wait_req("t5_lvl_a");
    do_ack();
    chk("t5_is0", 32'(in_service), 32'h01);
    chk("t5_lvl_pend", 32'(pending), 32'h01);
    idle_no_req("t5_same_lvl", 4);
    expect_req(3'd0, 10'h3C0);
    do_reti();
    wait_req("t5_lvl_b");
    do_ack();
    irq[0] = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_lvl_low", 32'(pending), 32'd0);
    do_reti();
    expect_req(3'd4, 10'h3D0);
    pulse_irq(8'h10);
    wait_req("t5_edge");
    do_ack();
    do_reti();
    idle_no_req("t5_edge_once", 8);
    chk("t5_pend0", 32'(pending), 32'd0);

    // table-driven single-line requests
    for (int k = 0; k < 4; k++) begin
      logic [7:0] bit_k;
      bit_k = 8'd1 << tbl[k].line;
      expect_req(tbl[k].id, tbl[k].vec);
      pulse_irq(bit_k);
      wait_req($sformatf("tbl%0d", k));
      do_ack();
      chk($sformatf("tbl%0d_is", k), 32'(in_service), 32'(tbl[k].is_exp));
      do_reti();
      chk($sformatf("tbl%0d_clr", k), 32'(in_service), 32'd0);
    end

    // 6: bad reti and asynchronous reset during REQ
    tick();
    do_reti();
    chk("t6_bad", 32'(bad_reti), 32'd1);
    chk("t6_is", 32'(in_service), 32'd0);
    tick();
    chk("t6_bad_clr", 32'(bad_reti), 32'd0);
    expect_req(3'd7, 10'h3DC);
    pulse_irq(8'h80);
    wait_req("t6_n7");
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_req", 32'(int_req), 32'd0);
    chk("t6_rst_vec", 32'(int_vec), 32'h3C0);
    chk("t6_rst_id", 32'(int_id), 32'd0);
    chk("t6_rst_mask", 32'(mask), 32'd0);
    #2 reset = 1'b1;
    idle_no_req("t6_post_rst", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
